// File: rtl/riscv_fetch_queue.sv
// riscv_fetch_queue: instruction fetch unit with a small decoupling queue.
// It issues sequential word reads to a one-cycle-latency instruction memory.
// Returned words are queued with their PCs, and the head is presented to the
// decode stage. A redirect flushes the queue and restarts fetch at a new target.
//
// Parameters:
//   RESET_PC   first fetch address after reset
//   DEPTH      queue entries (2, 4 or 8; must be a power of two)
//   NOP_INST   instruction shown on IF_INST while the queue is empty
// Ports:
//   CLK, RST      clock, asynchronous active-high reset
//   I_MEM_CSN     read strobe, active-low (this-cycle request)
//   I_MEM_ADDR    request byte address (always word aligned)
//   I_MEM_DI      read data, valid the cycle after a request
//   REDIRECT_EN   single-cycle redirect pulse from decode
//   REDIRECT_PC   redirect target (low two bits ignored)
//   ID_READY      decode consumes the head this cycle
//   IF_VALID      head entry valid
//   IF_INST       head instruction, NOP_INST when empty
//   IF_PC         head PC, zero when empty
module riscv_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        I_MEM_CSN,
    output logic [31:0] I_MEM_ADDR,
    input  logic [31:0] I_MEM_DI,
    input  logic        REDIRECT_EN,
    input  logic [31:0] REDIRECT_PC,
    input  logic        ID_READY,
    output logic        IF_VALID,
    output logic [31:0] IF_INST,
    output logic [31:0] IF_PC
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      pc;
    logic [31:0]      req_pc;
    logic             inflight;
    logic             discard;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [31:0] inst_mem [DEPTH];
    logic [31:0] pc_mem   [DEPTH];

    logic [CNT_W-1:0] occupancy;
    logic             issue;
    logic             push;
    logic             pop;
    logic             unused_redirect_lsb;

    assign unused_redirect_lsb = ^REDIRECT_PC[1:0];

    // Queued entries plus the outstanding request bound further issue.
    // A full queue can never overflow.
    assign occupancy = count + CNT_W'(inflight);
    assign issue     = !RST && !REDIRECT_EN && (occupancy < CNT_W'(DEPTH));
    assign push      = inflight && !discard && !REDIRECT_EN;
    assign pop       = (count != '0) && ID_READY && !REDIRECT_EN;

    assign I_MEM_CSN  = !issue;
    assign I_MEM_ADDR = pc;

    assign IF_VALID = (count != '0);
    assign IF_INST  = IF_VALID ? inst_mem[rd_ptr] : NOP_INST;
    assign IF_PC    = IF_VALID ? pc_mem[rd_ptr]   : 32'h0000_0000;

    // Control state: fetch PC, in-flight tracking, pointers and occupancy.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc       <= RESET_PC;
            req_pc   <= 32'h0000_0000;
            inflight <= 1'b0;
            discard  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (REDIRECT_EN) begin
            // A word returning in this cycle is dropped through the push gating.
            // discard also marks any response that is still owed to the old stream.
            pc       <= {REDIRECT_PC[31:2], 2'b00};
            inflight <= 1'b0;
            discard  <= inflight;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= issue;
            discard  <= 1'b0;
            if (issue) begin
                req_pc <= pc;
                pc     <= pc + 32'd4;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Queue storage: contents are qualified by count, so no reset is needed.
    always_ff @(posedge CLK) begin
        if (push) begin
            inst_mem[wr_ptr] <= I_MEM_DI;
            pc_mem[wr_ptr]   <= req_pc;
        end
    end

endmodule
